serial_add_seq: RTL

- Multi-cycle controller that computes a WIDTH-bit add or subtract by time-sharing one existing full_adder cell, one bit per clock, LSB first.
- Serves as the area-reduced mantissa add/sub engine inside the 32-bit floating point adder. It sits between the alignment stage and the normalisation stage.
- Uses a valid/ready handshake on both the input side and the output side.

---
 rtl/fp_add_pkg.sv | 11 +
 rtl/full_adder.sv | 17 +
 rtl/serial_add_seq.sv | 100 ++++++++++
 3 files changed

// File: rtl/fp_add_pkg.sv
// fp_add_pkg: shared constants for the FP32 adder slice.
// Holds mantissa width and serial add/sub FSM state codes.
package fp_add_pkg;

  localparam int MANT_W = 24;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

endpackage

// File: rtl/full_adder.sv
// full_adder: one-bit full adder cell, gate-level.
// Ports: A, B, Cin in; Sum, Cout out.
module full_adder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Sum,
  output logic Cout
);

  logic axb;

  assign axb  = A ^ B;
  assign Sum  = axb ^ Cin;
  assign Cout = (A & B) | (axb & Cin);

endmodule

// File: rtl/serial_add_seq.sv
// serial_add_seq: bit-serial WIDTH-bit add/sub, LSB first, one full_adder.
// Ports: clk/rst, in_valid/in_ready + A,B,Cin,op_sub; out_valid/out_ready + Sum,Cout,ovf.
module serial_add_seq
  import fp_add_pkg::*;
#(
  parameter int WIDTH = MANT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             ovf
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(WIDTH - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic             carry;
  logic             fa_s;
  logic             fa_c;
  logic [WIDTH-1:0] sum_nx;

  full_adder u_fa (
    .A    (a_sh[0]),
    .B    (b_sh[0]),
    .Cin  (carry),
    .Sum  (fa_s),
    .Cout (fa_c)
  );

  assign in_ready = (state == S_IDLE) & ~rst;

  // new bit enters at the MSB; after WIDTH
  // shifts bit 0 sits at the LSB
  assign sum_nx = {fa_s, sum_sh[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      a_sh      <= '0;
      b_sh      <= '0;
      sum_sh    <= '0;
      carry     <= 1'b0;
      Sum       <= '0;
      Cout      <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_sh  <= A;
            b_sh  <= op_sub ? ~B : B;
            carry <= op_sub | Cin;
            cnt   <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          sum_sh <= sum_nx;
          carry  <= fa_c;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            Sum       <= sum_nx;
            Cout      <= fa_c;
            // carry into MSB vs out of MSB
            ovf       <= carry ^ fa_c;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
